// File: rtl/wb_lane_serializer.sv
// Write-back lane serializer: single and 4-lane MEM/WB writes onto pixel-memory and register-file ports.
// Optional WB_LANE_MASK_EN adds lane_mask_in to skip lanes of a 4-lane request.
//
// state | meaning
// IDLE  | sampling MEM/WB bundle; single writes pass through, 4-lane requests captured
// DRAIN | issuing buffered lanes one per cycle, upstream stalled until the last lane
module wb_lane_serializer #(
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_pxl_in,
   input  logic              wr_pos_in,
   input  logic              wr_mul_pos_in,
   input  logic              wr_mul_reg_in,
   input  logic [31:0]       r1_in,
   input  logic [31:0]       r2_in,
   input  logic [31:0]       r3_in,
   input  logic [31:0]       r4_in,
   input  logic [31:0]       load1_in,
   input  logic [31:0]       load2_in,
   input  logic [31:0]       load3_in,
   input  logic [31:0]       load4_in,
`ifdef WB_LANE_MASK_EN
   input  logic [3:0]        lane_mask_in,
`endif
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [31:0]       rf_wdata,
   output logic              stall,
   output logic              err
);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t      state;
   logic [31:0] addr_buf [4];
   logic [31:0] data_buf [4];
   logic [31:0] r_in [4];
   logic [31:0] ld_in [4];
   logic        tgt_mem;
   logic [3:0]  pend;

   logic        mul_req;
   logic        conflict;
   logic [3:0]  cap_mask;
   logic [3:0]  src;
   logic [1:0]  sel;
   logic [3:0]  rest;
   logic [31:0] lane_addr;
   logic [31:0] lane_data;
   logic        lane_mem;

   assign r_in[0]  = r1_in;
   assign r_in[1]  = r2_in;
   assign r_in[2]  = r3_in;
   assign r_in[3]  = r4_in;
   assign ld_in[0] = load1_in;
   assign ld_in[1] = load2_in;
   assign ld_in[2] = load3_in;
   assign ld_in[3] = load4_in;

   always_comb begin
      mul_req  = wr_mul_pos_in | wr_mul_reg_in;
      conflict = (wr_mul_pos_in & (wr_mul_reg_in | wr_pxl_in | wr_pos_in)) |
                 (wr_mul_reg_in & (wr_pxl_in | wr_pos_in));
`ifdef WB_LANE_MASK_EN
      cap_mask = lane_mask_in;
`else
      cap_mask = 4'hF;
`endif
      // Lane 1 is issued straight from the inputs at the capture edge, later lanes from the buffer.
      src = (state == DRAIN) ? pend : cap_mask;
      sel = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (src[i]) sel = 2'(i);
      end
      rest      = src & ~(4'b0001 << sel);
      lane_addr = (state == DRAIN) ? addr_buf[sel] : r_in[sel];
      lane_data = (state == DRAIN) ? data_buf[sel] : ld_in[sel];
      lane_mem  = (state == DRAIN) ? tgt_mem : wr_mul_pos_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tgt_mem   <= 1'b0;
         pend      <= 4'h0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         stall     <= 1'b0;
         err       <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            addr_buf[i] <= '0;
            data_buf[i] <= '0;
         end
      end else begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         stall     <= 1'b0;
         case (state)
            IDLE: begin
               if (conflict) err <= 1'b1;
               if (mul_req) begin
                  addr_buf <= r_in;
                  data_buf <= ld_in;
                  tgt_mem  <= wr_mul_pos_in;
                  pend     <= rest;
                  if (src != 4'h0) begin
                     if (lane_mem) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= lane_addr;
                        mem_wdata <= lane_data;
                     end else begin
                        rf_we    <= 1'b1;
                        rf_waddr <= lane_addr[REG_AW-1:0];
                        rf_wdata <= lane_data;
                     end
                     if (rest != 4'h0) begin
                        state <= DRAIN;
                        stall <= 1'b1;
                     end
                  end
               end else begin
                  if (wr_pxl_in) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= r1_in;
                     mem_wdata <= load1_in;
                  end
                  if (wr_pos_in) begin
                     rf_we    <= 1'b1;
                     rf_waddr <= r1_in[REG_AW-1:0];
                     rf_wdata <= load1_in;
                  end
               end
            end
            DRAIN: begin
               if (lane_mem) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= lane_addr;
                  mem_wdata <= lane_data;
               end else begin
                  rf_we    <= 1'b1;
                  rf_waddr <= lane_addr[REG_AW-1:0];
                  rf_wdata <= lane_data;
               end
               pend <= rest;
               if (rest == 4'h0) begin
                  state <= IDLE;
               end else begin
                  stall <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
